list_prefetch: RTL and testbench



---
 rtl/list_prefetch.sv | 226 ++++++++++++++++++++++
 tb/tb_list_prefetch.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_prefetch.sv
// list_prefetch: prefetching element buffer between a list producer and its consumer.
//
// It pulls elements from the upstream list port ahead of demand, keeps up to DEPTH of them in
// a circular buffer, and latches end-of-list. Downstream requests are served from storage.
// List contents and order are never changed.
//
// Both list ports use the req/ack handshake:
//   - the requester raises req and holds it until ack;
//   - the responder pulses ack for one cycle with value/value_valid;
//   - value_valid=0 with ack marks end of list.
//
// Parameters
//   DATA_W  element width
//   DEPTH   storage entries (power of two, >= 2)
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high; clears all state
//   in_req           upstream element request (registered)
//   in_ack           upstream one-cycle acknowledge
//   in_value         upstream element, sampled when in_ack=1
//   in_value_valid   upstream 1 = element, 0 = end of list
//   out_req          downstream request; each rising edge asks for one element
//   out_ack          one-cycle acknowledge to downstream (registered)
//   out_value        element, valid while out_ack=1, otherwise 0 (registered)
//   out_value_valid  1 = element, 0 = end of list (registered)
//   level            stored element count; present only when LIST_PREFETCH_LEVEL_EN is defined
//
// Build option
//   LIST_PREFETCH_LEVEL_EN  adds the `level` output. Buffering is identical either way.

module list_prefetch #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    in_req,
  input  logic                    in_ack,
  input  logic [DATA_W-1:0]       in_value,
  input  logic                    in_value_valid,
  input  logic                    out_req,
  output logic                    out_ack,
  output logic [DATA_W-1:0]       out_value,
  output logic                    out_value_valid
`ifdef LIST_PREFETCH_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  level
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGap,
    StEnd
  } fetch_state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  fetch_state_e             state_q, state_d;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     end_seen_q, end_seen_d;
  logic                     pending_q, pending_d;
  logic                     out_req_q;
  logic                     in_req_q, in_req_d;
  logic                     out_ack_q, out_ack_d;
  logic [DATA_W-1:0]        out_value_q, out_value_d;
  logic                     out_valid_q, out_valid_d;

  logic                     push;
  logic                     pop;
  logic                     req_rise;

  // --------------------------------------------------------------------------
  // Fetch FSM
  // --------------------------------------------------------------------------
  // Only one fetch is ever in flight and it exists only in StReq, so the
  // "room for one more" test in StIdle reduces to count < DEPTH.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    end_seen_d = end_seen_q;

    unique case (state_q)
      StIdle: begin
        if (count_q < CntFull) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (in_ack) begin
          if (in_value_valid) begin
            push    = 1'b1;
            state_d = StGap;
          end else begin
            end_seen_d = 1'b1;
            state_d    = StEnd;
          end
        end
      end
      // One cycle with in_req low so upstream sees a fresh request.
      StGap: begin
        state_d = StIdle;
      end
      StEnd: begin
        state_d = StEnd;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    in_req_d = (state_d == StReq);
  end

  // --------------------------------------------------------------------------
  // Serve logic
  // --------------------------------------------------------------------------
  // A request is latched on the out_req rising edge and answered from the
  // registered pending flag, so acks always come from a flop. Guarding on
  // out_ack_q keeps acks from ever landing on back-to-back cycles even if a
  // requester re-raises out_req too early.
  always_comb begin
    req_rise    = out_req & ~out_req_q;
    pop         = 1'b0;
    out_ack_d   = 1'b0;
    out_value_d = '0;
    out_valid_d = 1'b0;
    pending_d   = pending_q | req_rise;

    if (pending_q && !out_ack_q) begin
      if (count_q != '0) begin
        pop         = 1'b1;
        out_ack_d   = 1'b1;
        out_value_d = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
        pending_d   = req_rise;
      end else if (end_seen_q) begin
        // Storage drained after end-of-list: every request gets an end marker.
        out_ack_d   = 1'b1;
        pending_d   = req_rise;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Buffer pointers and occupancy
  // --------------------------------------------------------------------------
  // Pointers are PTR_W bits wide, so wrapping modulo DEPTH is free.
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PtrOne) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      end_seen_q  <= 1'b0;
      pending_q   <= 1'b0;
      out_req_q   <= 1'b0;
      in_req_q    <= 1'b0;
      out_ack_q   <= 1'b0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      end_seen_q  <= end_seen_d;
      pending_q   <= pending_d;
      out_req_q   <= out_req;
      in_req_q    <= in_req_d;
      out_ack_q   <= out_ack_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_value;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_req          = in_req_q;
  assign out_ack         = out_ack_q;
  assign out_value       = out_value_q;
  assign out_value_valid = out_valid_q;

`ifdef LIST_PREFETCH_LEVEL_EN
  assign level = count_q;
`endif

endmodule

// File: tb/tb_list_prefetch.sv
// Self-checking bench for list_prefetch. An upstream list responder and a
// queue-based reference (list order in, same order out, then end markers)
// drive the expectations; level checks appear only when the level port exists.

module tb_list_prefetch;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_req;
  logic              in_ack;
  logic [DATA_W-1:0] in_value;
  logic              in_value_valid;
  logic              out_req;
  logic              out_ack;
  logic [DATA_W-1:0] out_value;
  logic              out_value_valid;
`ifdef LIST_PREFETCH_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  list_prefetch #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_req          (in_req),
    .in_ack          (in_ack),
    .in_value        (in_value),
    .in_value_valid  (in_value_valid),
    .out_req         (out_req),
    .out_ack         (out_ack),
    .out_value       (out_value),
    .out_value_valid (out_value_valid)
`ifdef LIST_PREFETCH_LEVEL_EN
    ,
    .level           (level)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference: the list handed to upstream, in order.
  logic [DATA_W-1:0] ref_q[$];

  // Upstream responder configuration and statistics.
  logic [DATA_W-1:0] up_list[$];
  bit up_end_ok = 1'b0;
  bit up_rand   = 1'b0;
  int up_delay  = 0;
  int up_wait   = 0;
  int up_acks   = 0;
  int up_ends   = 0;
  int up_last_ack_cyc = -1;
  int up_prev_ack_cyc = -1;

  always @(negedge clock) begin
    if (in_ack) begin
      in_ack = 1'b0;
      in_value = '0;
      in_value_valid = 1'b0;
    end else if (reset || !in_req) begin
      up_wait = 0;
    end else if (up_wait < up_delay) begin
      up_wait++;
    end else if (up_list.size() > 0) begin
      in_ack = 1'b1;
      in_value = up_list.pop_front();
      in_value_valid = 1'b1;
      up_acks++;
      up_prev_ack_cyc = up_last_ack_cyc;
      up_last_ack_cyc = cyc;
      up_wait = 0;
      if (up_rand) up_delay = int'($urandom_range(0, 4));
    end else if (up_end_ok) begin
      in_ack = 1'b1;
      in_value = '0;
      in_value_valid = 1'b0;
      up_ends++;
      up_last_ack_cyc = cyc;
      up_wait = 0;
    end
  end

  // Back-to-back out_ack watcher.
  int   dbl_ack  = 0;
  logic prev_ack = 1'b0;
  always @(negedge clock) begin
    if (out_ack === 1'b1 && prev_ack === 1'b1) dbl_ack++;
    prev_ack = out_ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_next(input string tag, input logic [DATA_W-1:0] val, input logic vv);
    logic [DATA_W-1:0] ev;
    logic              evv;
    if (ref_q.size() > 0) begin
      ev  = ref_q.pop_front();
      evv = 1'b1;
    end else begin
      ev  = '0;
      evv = 1'b0;
    end
    check({tag, "_value"}, 32'(val), 32'(ev));
    check({tag, "_valid"}, 32'(vv), 32'(evv));
  endtask

  // Called on a negedge. pulse: out_req high for one cycle only; keep: leave
  // out_req high after the ack. lat counts negedges from raising out_req.
  task automatic ds_req(input bit pulse, input bit keep, output bit got,
                        output logic [DATA_W-1:0] val, output logic vv,
                        output int lat, output int ack_cyc);
    int start;
    start = cyc; got = 1'b0; val = '0; vv = 1'b0; lat = -1; ack_cyc = -1;
    out_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (pulse) out_req = 1'b0;
      if (out_ack === 1'b1) begin
        got = 1'b1; val = out_value; vv = out_value_valid;
        ack_cyc = cyc; lat = cyc - start;
        break;
      end
    end
    check("ds_ack_seen", 32'(got), 32'd1);
    if (!keep) begin
      out_req = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic start_reset();
    reset = 1'b1;
    out_req = 1'b0;
    repeat (2) @(negedge clock);
    up_list.delete(); ref_q.delete();
    up_acks = 0; up_ends = 0; up_rand = 1'b0; up_delay = 0;
    up_last_ack_cyc = -1; up_prev_ack_cyc = -1;
  endtask

  initial begin
    bit got;
    logic [DATA_W-1:0] v, nv;
    logic vv;
    int lat, ack_cyc, n, acks;

    reset = 1'b1; out_req = 1'b0;
    in_ack = 1'b0; in_value = '0; in_value_valid = 1'b0;
    repeat (3) @(negedge clock);

    // Reset values.
    check("rst_in_req", 32'(in_req), 32'd0);
    check("rst_out_ack", 32'(out_ack), 32'd0);
    check("rst_out_value", 32'(out_value), 32'd0);
    check("rst_out_valid", 32'(out_value_valid), 32'd0);
`ifdef LIST_PREFETCH_LEVEL_EN
    check("rst_level", 32'(level), 32'd0);
`endif

    // Prefetch fill: 1..10 with immediate acks, no downstream demand.
    start_reset();
    for (int i = 1; i <= 10; i++) begin
      up_list.push_back(DATA_W'(i));
      ref_q.push_back(DATA_W'(i));
    end
    up_end_ok = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    check("fill_first_req", 32'(in_req), 32'd1);
    repeat (30) @(negedge clock);
    check("fill_up_acks", 32'(up_acks), 32'd4);
    check("fill_in_req_low", 32'(in_req), 32'd0);
    check("fill_spacing", 32'(up_last_ack_cyc - up_prev_ack_cyc), 32'd3);
`ifdef LIST_PREFETCH_LEVEL_EN
    check("fill_level", 32'(level), 32'd4);
`endif

    // Ordered drain: 1-high/2-low pulses, then one more for end of list.
    for (int i = 0; i < 11; i++) begin
      ds_req(1'b1, 1'b0, got, v, vv, lat, ack_cyc);
      expect_next("drain", v, vv);
      check("drain_latency", 32'(lat), 32'd2);
    end
    check("drain_up_acks", 32'(up_acks), 32'd10);
    check("drain_up_ends", 32'(up_ends), 32'd1);
    check("drain_in_req_end", 32'(in_req), 32'd0);
`ifdef LIST_PREFETCH_LEVEL_EN
    check("drain_level", 32'(level), 32'd0);
`endif

    // End latch: empty list.
    start_reset();
    up_end_ok = 1'b1;
    up_delay = int'($urandom_range(0, 4));
    reset = 1'b0;
    repeat (15) @(negedge clock);
    check("end_up_ends", 32'(up_ends), 32'd1);
    check("end_in_req_low", 32'(in_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ds_req(1'b0, 1'b0, got, v, vv, lat, ack_cyc);
      expect_next("end_marker", v, vv);
      check("end_latency", 32'(lat), 32'd2);
    end
    check("end_in_req_stays_low", 32'(in_req), 32'd0);

    // Miss path: request waits for a slow upstream delivering 8'h2A.
    start_reset();
    up_list.push_back(8'h2A); ref_q.push_back(8'h2A);
    up_end_ok = 1'b0;
    up_delay = 5;
    reset = 1'b0;
    ds_req(1'b0, 1'b1, got, v, vv, lat, ack_cyc);
    expect_next("miss", v, vv);
    check("miss_ack_after_in_ack", 32'(ack_cyc - up_last_ack_cyc), 32'd2);
    acks = 0;
    repeat (5) begin
      @(negedge clock);
      if (out_ack === 1'b1) acks++;
    end
    check("miss_held_req_no_ack", 32'(acks), 32'd0);
    out_req = 1'b0;
`ifdef LIST_PREFETCH_LEVEL_EN
    check("miss_level", 32'(level), 32'd0);
`endif

    // Simultaneous push/pop at count=2, across pointer wrap.
    start_reset();
    for (int i = 0; i < 2; i++) begin
      nv = DATA_W'($urandom);
      up_list.push_back(nv); ref_q.push_back(nv);
    end
    up_end_ok = 1'b0;
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check("pp_stalled_req", 32'(in_req), 32'd1);
`ifdef LIST_PREFETCH_LEVEL_EN
    check("pp_level_start", 32'(level), 32'd2);
`endif
    for (int i = 0; i < 9; i++) begin
      out_req = 1'b1;
      @(posedge clock);
      #1;
      nv = DATA_W'($urandom);
      up_list.push_back(nv); ref_q.push_back(nv);
      @(negedge clock);
      out_req = 1'b0;
      @(negedge clock);
      check("pp_ack", 32'(out_ack), 32'd1);
      expect_next("pp", out_value, out_value_valid);
`ifdef LIST_PREFETCH_LEVEL_EN
      check("pp_level", 32'(level), 32'd2);
`endif
      @(negedge clock);
    end

    // Reset mid-operation with a pending request and in_req high.
    start_reset();
    up_end_ok = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    out_req = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_pending_no_ack", 32'(out_ack), 32'd0);
    check("mid_in_req", 32'(in_req), 32'd1);
    reset = 1'b1;
    out_req = 1'b0;
    @(negedge clock);
    check("mid_rst_in_req", 32'(in_req), 32'd0);
    check("mid_rst_out_ack", 32'(out_ack), 32'd0);
    check("mid_rst_out_value", 32'(out_value), 32'd0);
    check("mid_rst_out_valid", 32'(out_value_valid), 32'd0);
`ifdef LIST_PREFETCH_LEVEL_EN
    check("mid_rst_level", 32'(level), 32'd0);
`endif
    up_list.delete(); ref_q.delete();
    up_list.push_back(8'd7); up_list.push_back(8'd8);
    ref_q.push_back(8'd7); ref_q.push_back(8'd8);
    up_end_ok = 1'b1;
    reset = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clock);
      if (out_ack === 1'b1) acks++;
    end
    check("mid_no_stale_ack", 32'(acks), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ds_req(1'b0, 1'b0, got, v, vv, lat, ack_cyc);
      expect_next("mid_fresh", v, vv);
    end

    // Randomized list with random upstream delays and downstream gaps.
    start_reset();
    n = int'($urandom_range(3, 12));
    for (int i = 0; i < n; i++) begin
      nv = DATA_W'($urandom);
      up_list.push_back(nv); ref_q.push_back(nv);
    end
    up_end_ok = 1'b1;
    up_rand = 1'b1;
    up_delay = int'($urandom_range(0, 4));
    reset = 1'b0;
    for (int i = 0; i < n + 2; i++) begin
      repeat (int'($urandom_range(0, 5))) @(negedge clock);
      ds_req(1'b0, 1'b0, got, v, vv, lat, ack_cyc);
      expect_next("rand", v, vv);
    end
    check("rand_up_acks", 32'(up_acks), 32'(n));
    check("rand_in_req_end", 32'(in_req), 32'd0);

    check("no_back_to_back_ack", 32'(dbl_ack), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
